// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: op codes, FSM state encoding,
// datapath step modes and the iteration-counter width helper.
package muldiv_pkg;

    localparam logic [2:0] OP_SDIV  = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_SMULL = 3'b101;
    localparam logic [2:0] OP_UMULL = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef enum logic {
        ModeMul,
        ModeDiv
    } step_mode_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift/add for multiply, shift/restoring-subtract for divide.
// Accumulator holds {partial product, multiplier} or {remainder, quotient}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  step_mode_e         mode,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        // Extra top bit keeps the shifted remainder exact before the compare.
        shifted_rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff        = shifted_rem[WIDTH-1:0] - operand;
        acc_next    = '0;
        if (mode == ModeDiv) begin
            if (shifted_rem >= {1'b0, operand}) begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {shifted_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer (MUL, UMULL, SMULL, DIV) over one radix-2 datapath.
// Define MULDIV_SIGNED_DIV_EN to add SDIV on op 3'b011.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             div_by_zero
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [2:0]         state_q, state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, opnd_q;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   res_lo_q, res_hi_q;
    logic [2*WIDTH-1:0] acc_q, acc_next;
    logic [CW-1:0]      cnt_q;
    logic               neg_q, dbz_pend_q, dbz_q;
    logic               legal, div_op;
    step_mode_e         mode;
`ifdef MULDIV_SIGNED_DIV_EN
    logic               rem_neg_q;
`endif

    always_comb begin
        legal = (op == OP_DIV) || (op == OP_SMULL) || (op == OP_UMULL) || (op == OP_MUL);
`ifdef MULDIV_SIGNED_DIV_EN
        legal  = legal || (op == OP_SDIV);
        div_op = (op_q == OP_DIV) || (op_q == OP_SDIV);
`else
        div_op = (op_q == OP_DIV);
`endif
        mode  = div_op ? ModeDiv : ModeMul;
        a_mag = a_q[WIDTH-1] ? -a_q : a_q;
        b_mag = b_q[WIDTH-1] ? -b_q : b_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && legal) state_d = S_PREP;
            S_PREP:  state_d = S_ITER;
            S_ITER:  if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .acc     (acc_q),
        .operand (opnd_q),
        .mode    (mode),
        .acc_next(acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            opnd_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
`ifdef MULDIV_SIGNED_DIV_EN
            rem_neg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start && legal) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        dbz_q <= 1'b0;
                    end
                end
                S_PREP: begin
                    cnt_q      <= CW'(WIDTH - 1);
                    neg_q      <= 1'b0;
                    dbz_pend_q <= 1'b0;
`ifdef MULDIV_SIGNED_DIV_EN
                    rem_neg_q  <= 1'b0;
`endif
                    case (op_q)
                        OP_SMULL: begin
                            opnd_q <= a_mag;
                            acc_q  <= {{WIDTH{1'b0}}, b_mag};
                            neg_q  <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                        end
                        OP_DIV: begin
                            opnd_q     <= b_q;
                            acc_q      <= {{WIDTH{1'b0}}, a_q};
                            dbz_pend_q <= (b_q == '0);
                        end
`ifdef MULDIV_SIGNED_DIV_EN
                        OP_SDIV: begin
                            opnd_q     <= b_mag;
                            acc_q      <= {{WIDTH{1'b0}}, a_mag};
                            neg_q      <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                            rem_neg_q  <= a_q[WIDTH-1];
                            dbz_pend_q <= (b_q == '0);
                        end
`endif
                        default: begin
                            opnd_q <= a_q;
                            acc_q  <= {{WIDTH{1'b0}}, b_q};
                        end
                    endcase
                end
                S_ITER: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q - CW'(1);
                end
                S_FIX: begin
                    if (dbz_pend_q) begin
                        // Divide by zero reports all-ones quotient and the original dividend.
                        res_lo_q <= '1;
                        res_hi_q <= a_q;
                        dbz_q    <= 1'b1;
                    end else begin
                        case (op_q)
                            OP_SMULL: {res_hi_q, res_lo_q} <= neg_q ? -acc_q : acc_q;
                            OP_MUL: begin
                                res_lo_q <= acc_q[WIDTH-1:0];
                                res_hi_q <= '0;
                            end
`ifdef MULDIV_SIGNED_DIV_EN
                            OP_SDIV: begin
                                res_lo_q <= neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                                res_hi_q <= rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH]
                                                      : acc_q[2*WIDTH-1:WIDTH];
                            end
`endif
                            default: {res_hi_q, res_lo_q} <= acc_q;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign res_lo      = res_lo_q;
    assign res_hi      = res_hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: issued ops push reference results, a monitor pops on done.
// Honours MULDIV_SIGNED_DIV_EN when the design is built with it.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       op = 3'b000;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, div_by_zero;
    logic [WIDTH-1:0] res_lo, res_hi;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned busy_run = 0;

    muldiv_seq #(
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .res_lo     (res_lo),
        .res_hi     (res_hi),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic legal_op(input logic [2:0] o);
        logic ok;
        ok = (o == OP_DIV) || (o == OP_SMULL) || (o == OP_UMULL) || (o == OP_MUL);
`ifdef MULDIV_SIGNED_DIV_EN
        ok = ok || (o == OP_SDIV);
`endif
        return ok;
    endfunction

    // Reference results from plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y, input string nm);
        exp_t        e;
        longint      sx, sy;
        logic [63:0] p;
        e.name = nm;
        e.dbz  = 1'b0;
        e.cyc  = 0;
        e.lo   = '0;
        e.hi   = '0;
        sx     = $signed(x);
        sy     = $signed(y);
        case (o)
            OP_UMULL: begin
                p    = {32'd0, x} * {32'd0, y};
                e.lo = p[31:0];
                e.hi = p[63:32];
            end
            OP_SMULL: begin
                p    = 64'(sx * sy);
                e.lo = p[31:0];
                e.hi = p[63:32];
            end
            OP_MUL: e.lo = x * y;
            OP_DIV: begin
                if (y == 0) begin
                    e.lo  = 32'hFFFF_FFFF;
                    e.hi  = x;
                    e.dbz = 1'b1;
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
`ifdef MULDIV_SIGNED_DIV_EN
            OP_SDIV: begin
                if (y == 0) begin
                    e.lo  = 32'hFFFF_FFFF;
                    e.hi  = x;
                    e.dbz = 1'b1;
                end else begin
                    p    = 64'(sx / sy);
                    e.lo = p[31:0];
                    p    = 64'(sx % sy);
                    e.hi = p[31:0];
                end
            end
`endif
            default: ;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string nm);
        exp_t        e;
        int unsigned guard = 0;
        @(negedge clk);
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_wait actual=busy required=idle", nm);
        end
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        if (legal_op(o)) begin
            e     = model(o, x, y, nm);
            // done is seen at the negedge WIDTH+2 edges after the accepting edge.
            e.cyc = cyc + WIDTH + 2;
            sb_q.push_back(e);
        end
        @(negedge clk);
        check({nm, "_accept"}, 64'(busy), 64'(legal_op(o)));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            else busy_run = 0;
            if (done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done required=no_done lo=%0h", res_lo);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_lo"}, 64'(res_lo), 64'(e.lo));
                    check({e.name, "_hi"}, 64'(res_hi), 64'(e.hi));
                    check({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
                    check({e.name, "_latency"}, 64'(cyc), 64'(e.cyc));
                    check({e.name, "_busy_len"}, 64'(busy_run), 64'(WIDTH + 3));
                end
            end
        end
    end

    initial begin
        logic [2:0]  ops[$];
        logic [31:0] x, y;
        int unsigned g;

        ops = '{OP_DIV, OP_SMULL, OP_UMULL, OP_MUL};
`ifdef MULDIV_SIGNED_DIV_EN
        ops.push_back(OP_SDIV);
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_lo", 64'(res_lo), 0);
        check("rst_hi", 64'(res_hi), 0);
        check("rst_dbz", 64'(div_by_zero), 0);
        reset = 1'b0;

        issue(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umull_max");
        issue(OP_SMULL, 32'hFFFF_FFFE, 32'h0000_0003, "smull_neg");
        issue(OP_SMULL, 32'h8000_0000, 32'h8000_0000, "smull_minmin");
        issue(OP_MUL, 32'h0001_0001, 32'h0001_0001, "mul");
        issue(OP_DIV, 32'd100, 32'd7, "div_100_7");
        issue(OP_DIV, 32'h1234_5678, 32'd0, "div_zero");
        issue(OP_DIV, 32'd10, 32'd5, "div_after_zero");

        // A start during ITER must be ignored.
        issue(OP_UMULL, 32'h0000_1234, 32'h0000_5678, "umull_mid_start");
        repeat (10) @(negedge clk);
        start = 1'b1;
        op    = OP_MUL;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
        @(negedge clk);
        start = 1'b0;

        issue(3'b000, 32'd5, 32'd6, "illegal_op");
        repeat (3) @(negedge clk);
        check("illegal_idle", 64'(busy), 0);

        // Back-to-back: the second issue lands in the IDLE cycle right after done.
        issue(OP_MUL, 32'd3, 32'd4, "b2b_first");
        g = 0;
        while (!done && g < 100) begin
            @(negedge clk);
            g++;
        end
        issue(OP_UMULL, 32'd7, 32'd9, "b2b_second");

        // Abort by reset at cycle N+10.
        issue(OP_UMULL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umull_abort");
        repeat (9) @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("abort_busy", 64'(busy), 0);
        check("abort_done", 64'(done), 0);
        check("abort_lo", 64'(res_lo), 0);
        check("abort_hi", 64'(res_hi), 0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_quiet", 64'(busy), 0);

`ifdef MULDIV_SIGNED_DIV_EN
        issue(OP_SDIV, 32'hFFFF_FFF9, 32'd2, "sdiv_m7_2");
        issue(OP_SDIV, 32'hFFFF_FFF9, 32'd0, "sdiv_zero");
`endif

        for (int i = 0; i < 40; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: x = 32'h8000_0000;
                2: y = $urandom_range(1, 15);
                3: y = 32'hFFFF_FFFF;
                default: ;
            endcase
            issue(ops[$urandom_range(0, ops.size() - 1)], x, y, "rand");
        end

        g = 0;
        while (sb_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("drain_pending", 64'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multi-cycle multiply/divide sequencer for the multi-cycle ARM core.
- Executes MUL, UMULL, SMULL and unsigned DIV over one shared radix-2 shift/add-subtract datapath.
- The main FSM issues `start` from its execute state and holds that state while `busy` is high.
- On `done`, the register file writes `res_lo` to Rd and, for long multiplies, `res_hi` to the high-result register.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  3  operation select, same encoding as ALUControl: 3'b100 DIV (unsigned), 3'b101 SMULL, 3'b110 UMULL, 3'b111 MUL
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; results valid from this cycle onward
- res_lo  out  WIDTH  product low half, or quotient
- res_hi  out  WIDTH  product high half, or remainder; 0 for MUL
- div_by_zero  out  1  set with done when op=DIV and b=0

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
  - State returns to IDLE; all outputs and internal registers clear to 0.
  - Reset during a running operation aborts it: no `done` is produced and results read 0.
- States: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- IDLE:
  - `start`=1 with a legal op latches a, b and op, then moves to PREP.
  - Illegal op (000-011) is ignored and the block stays in IDLE.
- PREP:
  - SMULL: converts a and b to magnitudes and records neg = a[MSB]^b[MSB].
  - Other ops: neg = 0.
  - Clears the 2*WIDTH accumulator and loads the iteration counter with WIDTH-1.
- ITER: exactly WIDTH cycles, one bit per cycle.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half; then shift the accumulator right 1.
  - Divide (restoring): shift {rem, quo} left 1; if rem >= b, subtract b and set the quotient LSB.
  - The counter decrements each cycle; the block leaves ITER when counter==0.
- FIX:
  - SMULL with neg=1: two's-complement negate the 2*WIDTH result.
  - MUL: forces res_hi to 0.
- DONE:
  - `done`=1 for exactly one cycle; return to IDLE next cycle.
  - Results stay stable until the next accepted `start`.
- Latency: `start` sampled at cycle N gives `done` at cycle N+WIDTH+3 (35 cycles for WIDTH=32), identical for all ops.
- `busy` is 1 from cycle N+1 through the DONE cycle inclusive.
- `start` while `busy` is ignored. No queuing. Inputs a, b and op are don't-care after acceptance.
- Back-to-back: `start` in the cycle immediately after DONE (IDLE) is accepted.
- Divide by zero: runs the normal latency. Result is quotient = all ones, remainder = a, div_by_zero = 1. div_by_zero clears on the next accepted `start`.
- Arithmetic is modulo 2^(2*WIDTH). Most-negative SMULL operands, e.g. (-2^31) x (-2^31), must yield +2^62 exactly.

Optional Feature:
- Macro: MULDIV_SIGNED_DIV_EN.
- Defined:
  - Op 3'b011 = SDIV, accepted like the other legal ops.
  - PREP takes magnitudes of a and b. FIX negates the quotient if signs differ and negates the remainder if a was negative (truncation toward zero).
  - SDIV by zero gives quotient = all ones, remainder = a, div_by_zero = 1.
- Undefined: op 3'b011 is illegal and ignored in IDLE; no SDIV logic is synthesised.

Decomposition:
- Package muldiv_pkg holds:
  - op localparams: OP_DIV, OP_SMULL, OP_UMULL, OP_MUL, OP_SDIV;
  - state encoding: S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE;
  - a counter-width function, $clog2(WIDTH).
- One natural sub-module, muldiv_step: the combinational single-iteration datapath.
  - Inputs: accumulator, operand, mode.
  - Output: next accumulator.
  - Instantiated once in muldiv_seq. The top keeps the FSM, counter, sign handling and output registers.

Test Plan:
- UMULL a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle N+35; res_hi=0xFFFFFFFE, res_lo=0x00000001; busy high for exactly 35 cycles.
- SMULL a=0xFFFFFFFE (-2), b=0x00000003 -> res_hi=0xFFFFFFFF, res_lo=0xFFFFFFFA. SMULL a=b=0x80000000 -> res_hi=0x40000000, res_lo=0.
- MUL a=0x00010001, b=0x00010001 -> res_lo=0x00020001, res_hi=0. DIV a=100, b=7 -> res_lo=14, res_hi=2, div_by_zero=0.
- DIV a=0x12345678, b=0 -> res_lo=0xFFFFFFFF, res_hi=0x12345678, div_by_zero=1. Next DIV 10/5 -> div_by_zero=0, res_lo=2.
- `start` pulsed mid-ITER with different operands -> ignored, first result unchanged. `start` in the cycle after `done` -> accepted. op=3'b000 in IDLE -> busy stays 0.
- reset asserted at cycle N+10 of a UMULL -> next cycle IDLE, busy=0, res_lo=res_hi=0, no `done` pulse. With MULDIV_SIGNED_DIV_EN, SDIV -7/2 -> res_lo=0xFFFFFFFD, res_hi=0xFFFFFFFF.
